// File: rtl/cpu_pkg.sv
// Shared constants for the accumulator CPU: widths, opcodes and controller state encodings.
package cpu_pkg;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;

    localparam logic [2:0] OP_IN   = 3'b011;
    localparam logic [2:0] OP_OUT  = 3'b100;
    localparam logic [2:0] OP_DEC  = 3'b101;
    localparam logic [2:0] OP_JNZ  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam logic [1:0] ST_FETCH  = 2'd0;
    localparam logic [1:0] ST_DECODE = 2'd1;
    localparam logic [1:0] ST_EXEC   = 2'd2;
    localparam logic [1:0] ST_HALT   = 2'd3;

    function automatic logic [2:0] opcode_of(input logic [DATA_W-1:0] instr);
        return instr[7:5];
    endfunction
endpackage

// File: rtl/datapath_if.sv
// Controller <-> datapath link: control strobes one way, IR and A-nonzero flag back.
interface datapath_if;
    import cpu_pkg::*;

    logic              ir_load;
    logic              pc_load;
    logic              jnz_mux;
    logic              inmux;
    logic              a_load;
    logic              halt;
    logic [DATA_W-1:0] ir;
    logic              an_0;

    modport master (
        output ir_load, pc_load, jnz_mux, inmux, a_load, halt,
        input  ir, an_0
    );

    modport slave (
        input  ir_load, pc_load, jnz_mux, inmux, a_load, halt,
        output ir, an_0
    );
endinterface

// File: rtl/prog_mem.sv
// Program memory: asynchronous read port (instruction fetch), synchronous write port (loader).
module prog_mem
    import cpu_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = ADDR_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem_reg [2**AW];

    // Read is combinational, so a same-cycle write is only visible after the edge.
    assign rdata = mem_reg[raddr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end
endmodule

// File: rtl/datapath.sv
// Accumulator CPU datapath: PC, IR, A, sticky halt flag and program memory, obeying controller strobes.
module datapath
    import cpu_pkg::*;
(
    input  logic              clock,
    input  logic              clear,
    datapath_if.slave         ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [DATA_W-1:0] ir_reg, ir_next;
    logic [DATA_W-1:0] a_reg, a_next;
    logic              halted_reg, halted_next;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_we;

    // A write in the same cycle as clear is dropped.
    assign mem_we = prog_we & ~clear;

    prog_mem #(
        .DW (DATA_W),
        .AW (ADDR_W)
    ) u_prog_mem (
        .clk   (clock),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc_reg),
        .rdata (mem_rdata)
    );

    always_comb begin
        pc_next     = pc_reg;
        ir_next     = ir_reg;
        a_next      = a_reg;
        halted_next = halted_reg | ctrl.halt;
        if (!halted_reg) begin
            if (ctrl.pc_load) begin
                pc_next = ctrl.jnz_mux ? ir_reg[ADDR_W-1:0] : pc_reg + ADDR_W'(1);
            end
            if (ctrl.ir_load) begin
                ir_next = mem_rdata;
            end
            if (ctrl.a_load) begin
                a_next = ctrl.inmux ? in_data : a_reg - DATA_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            pc_reg     <= '0;
            ir_reg     <= '0;
            a_reg      <= '0;
            halted_reg <= 1'b0;
        end else begin
            pc_reg     <= pc_next;
            ir_reg     <= ir_next;
            a_reg      <= a_next;
            halted_reg <= halted_next;
        end
    end

    assign ctrl.ir   = ir_reg;
    assign ctrl.an_0 = |a_reg;
    assign out_data  = a_reg;
    assign pc        = pc_reg;
    assign halted    = halted_reg;
endmodule

// File: tb/tb_datapath.sv
// Scoreboard bench for datapath: stimulus queues expected register values, a negedge monitor checks them.
module tb_datapath;
    import cpu_pkg::*;

    logic              clock = 1'b0;
    logic              clear = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              prog_we = 1'b0;
    logic [ADDR_W-1:0] prog_addr = '0;
    logic [DATA_W-1:0] prog_data = '0;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] pc;
    logic              halted;

    datapath_if dp_bus ();

    datapath dut (
        .clock     (clock),
        .clear     (clear),
        .ctrl      (dp_bus),
        .in_data   (in_data),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .out_data  (out_data),
        .pc        (pc),
        .halted    (halted)
    );

    always #5 clock = ~clock;

    localparam int SEL_PC = 0, SEL_IR = 1, SEL_A = 2, SEL_AN0 = 3, SEL_HALT = 4, SEL_DECS = 5;

    typedef struct {
        string      name;
        int         sel;
        logic [7:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   dec_cnt = 0;

    function automatic logic [7:0] actual(input int sel);
        case (sel)
            SEL_PC:   return {3'b000, pc};
            SEL_IR:   return dp_bus.ir;
            SEL_A:    return out_data;
            SEL_AN0:  return {7'b0, dp_bus.an_0};
            SEL_HALT: return {7'b0, halted};
            default:  return dec_cnt[7:0];
        endcase
    endfunction

    // Monitor: outputs are stable by the falling edge after each stimulus edge.
    always @(negedge clock) begin
        while (exp_q.size() > 0) begin
            exp_t       e;
            logic [7:0] act;
            e   = exp_q.pop_front();
            act = actual(e.sel);
            n_cmp++;
            if (act !== e.val) begin
                n_bad++;
                $display("FAIL %s: got %02h want %02h", e.name, act, e.val);
            end else begin
                $display("ok   %s: %02h", e.name, act);
            end
        end
    end

    task automatic expect_val(input string name, input int sel, input logic [7:0] val);
        exp_q.push_back('{name, sel, val});
    endtask

    task automatic expect_state(input string tag, input logic [7:0] e_pc, input logic [7:0] e_ir,
                                input logic [7:0] e_a, input logic e_halt);
        expect_val({tag, ".pc"}, SEL_PC, e_pc);
        expect_val({tag, ".ir"}, SEL_IR, e_ir);
        expect_val({tag, ".a"}, SEL_A, e_a);
        expect_val({tag, ".an_0"}, SEL_AN0, {7'b0, (e_a != 8'h00)});
        expect_val({tag, ".halted"}, SEL_HALT, {7'b0, e_halt});
    endtask

    // Apply the currently driven inputs for one edge, then return strobes to idle.
    task automatic tick();
        @(posedge clock);
        #1;
        dp_bus.ir_load = 1'b0;
        dp_bus.pc_load = 1'b0;
        dp_bus.jnz_mux = 1'b0;
        dp_bus.inmux   = 1'b0;
        dp_bus.a_load  = 1'b0;
        dp_bus.halt    = 1'b0;
        clear          = 1'b0;
        prog_we        = 1'b0;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        prog_we = 1'b1; prog_addr = addr; prog_data = data;
        tick();
    endtask

    task automatic fetch();
        dp_bus.ir_load = 1'b1; dp_bus.pc_load = 1'b1;
        tick();
    endtask

    task automatic load_a(input logic [DATA_W-1:0] v);
        dp_bus.a_load = 1'b1; dp_bus.inmux = 1'b1; in_data = v;
        tick();
    endtask

    task automatic dec_a();
        dp_bus.a_load = 1'b1;
        tick();
    endtask

    task automatic jump();
        dp_bus.pc_load = 1'b1; dp_bus.jnz_mux = 1'b1;
        tick();
    endtask

    // Behavioural stand-in for the controller: fetch, then one execute cycle per instruction.
    task automatic run_program();
        logic [2:0] op;
        int         guard;
        op    = 3'b000;
        guard = 0;
        while (op != OP_HALT && guard < 40) begin
            fetch();
            op = opcode_of(dp_bus.ir);
            case (op)
                OP_IN:   begin dp_bus.a_load = 1'b1; dp_bus.inmux = 1'b1; end
                OP_DEC:  begin dp_bus.a_load = 1'b1; dec_cnt++; end
                OP_JNZ:  begin
                    if (dp_bus.an_0) begin
                        dp_bus.pc_load = 1'b1; dp_bus.jnz_mux = 1'b1;
                    end
                end
                OP_HALT: dp_bus.halt = 1'b1;
                default: ;
            endcase
            tick();
            guard++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        dp_bus.ir_load = 1'b0; dp_bus.pc_load = 1'b0; dp_bus.jnz_mux = 1'b0;
        dp_bus.inmux   = 1'b0; dp_bus.a_load  = 1'b0; dp_bus.halt    = 1'b0;
        #1;
        clear = 1'b1;
        tick();
        expect_state("reset", 8'h00, 8'h00, 8'h00, 1'b0);

        wr(5'd0, 8'hDF);
        wr(5'd1, 8'hC3);
        wr(5'd2, 8'h11);
        wr(5'd3, 8'hC2);
        wr(5'd31, 8'h60);

        // Dirty the registers, then clear with every strobe and a write asserted.
        fetch();
        load_a(8'hA5);
        expect_state("dirty", 8'h01, 8'hDF, 8'hA5, 1'b0);
        dp_bus.ir_load = 1'b1; dp_bus.pc_load = 1'b1; dp_bus.a_load = 1'b1;
        dp_bus.inmux = 1'b1; dp_bus.halt = 1'b1; in_data = 8'h44;
        prog_we = 1'b1; prog_addr = 5'd2; prog_data = 8'h77;
        clear = 1'b1;
        tick();
        expect_state("clear_all", 8'h00, 8'h00, 8'h00, 1'b0);

        fetch();
        expect_state("mem_kept", 8'h01, 8'hDF, 8'h00, 1'b0);
        jump();
        expect_val("jmp31.pc", SEL_PC, 8'h1F);
        fetch();
        expect_val("wrap.ir", SEL_IR, 8'h60);
        expect_val("wrap.pc", SEL_PC, 8'h00);

        load_a(8'h01);
        expect_val("in1.a", SEL_A, 8'h01);
        expect_val("in1.an_0", SEL_AN0, 8'h01);
        dec_a();
        expect_val("dec0.a", SEL_A, 8'h00);
        expect_val("dec0.an_0", SEL_AN0, 8'h00);
        dec_a();
        expect_val("decff.a", SEL_A, 8'hFF);
        expect_val("decff.an_0", SEL_AN0, 8'h01);

        fetch();
        fetch();
        expect_state("ir_c3", 8'h02, 8'hC3, 8'hFF, 1'b0);
        load_a(8'h05);
        jump();
        expect_val("jnz_taken.pc", SEL_PC, 8'h03);
        load_a(8'h00);
        tick();
        expect_val("jnz_not.pc", SEL_PC, 8'h03);

        // Fetch and write the same address: IR must take the old word.
        dp_bus.ir_load = 1'b1; dp_bus.pc_load = 1'b1;
        prog_we = 1'b1; prog_addr = 5'd3; prog_data = 8'h55;
        tick();
        expect_val("rw_same.ir", SEL_IR, 8'hC2);
        expect_val("rw_same.pc", SEL_PC, 8'h04);
        jump();
        fetch();
        expect_val("dropped_wr.ir", SEL_IR, 8'h11);

        // Full program: IN, DEC, JNZ 1, HALT with in_data = 3.
        clear = 1'b1;
        tick();
        wr(5'd0, 8'h60);
        wr(5'd1, 8'hA0);
        wr(5'd2, 8'hC1);
        wr(5'd3, 8'hE0);
        in_data = 8'h03;
        dec_cnt = 0;
        run_program();
        expect_state("prog", 8'h04, 8'hE0, 8'h00, 1'b1);
        expect_val("prog.decs", SEL_DECS, 8'h03);

        // Halted: every strobe ignored, but the loader still writes.
        dp_bus.ir_load = 1'b1; dp_bus.pc_load = 1'b1; dp_bus.jnz_mux = 1'b1;
        dp_bus.a_load = 1'b1; dp_bus.inmux = 1'b1; dp_bus.halt = 1'b1; in_data = 8'h99;
        prog_we = 1'b1; prog_addr = 5'd0; prog_data = 8'hA0;
        tick();
        expect_state("halt_hold", 8'h04, 8'hE0, 8'h00, 1'b1);
        clear = 1'b1;
        tick();
        expect_state("resume", 8'h00, 8'h00, 8'h00, 1'b0);
        fetch();
        expect_val("halt_wr.ir", SEL_IR, 8'hA0);
        expect_val("halt_wr.pc", SEL_PC, 8'h01);

        repeat (2) @(negedge clock);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/datapath.md
# datapath

Accumulator-machine datapath driven by the `control` FSM: holds the program counter, instruction register, accumulator and a writable program memory. It executes the control strobes each clock, and returns `ir` and the accumulator-nonzero flag `an_0` to the controller. Together with `control` it forms the complete CPU core; the bench preloads programs through the memory write port.

## Interface
- `DATA_W`, 8: width of the accumulator, instruction, memory word and I/O data.
- `ADDR_W`, 5: PC and memory address width; the jump target is `ir[ADDR_W-1:0]`.
- `clock`  in  1  single clock; all state changes on its rising edge.
- `clear`  in  1  reset, synchronous and active-high.
- `ir_load`  in  1  IR ← mem[PC].
- `pc_load`  in  1  PC update enable.
- `jnz_mux`  in  1  PC source select: 0 = PC+1, 1 = `ir[ADDR_W-1:0]`.
- `inmux`  in  1  A source select: 1 = `in_data`, 0 = A−1.
- `a_load`  in  1  A update enable.
- `halt`  in  1  enter the halted state.
- `in_data`  in  DATA_W  external input port, sampled on an IN load.
- `prog_we`  in  1  program memory write enable.
- `prog_addr`  in  ADDR_W  program write address.
- `prog_data`  in  DATA_W  program write data.
- `ir`  out  DATA_W  instruction register, to the controller.
- `an_0`  out  1  1 when A ≠ 0. Combinational from A.
- `out_data`  out  DATA_W  direct copy of A; the OUT instruction is this port.
- `pc`  out  ADDR_W  current PC, for debug and the bench.
- `halted`  out  1  sticky halt flag.

## Operation
- ISA uses `ir[7:5]` as the opcode and `ir[4:0]` as the operand.
  - 011 IN: A ← in_data.
  - 100 OUT: A is visible on `out_data`; no register changes.
  - 101 DEC: A ← A−1.
  - 110 JNZ: if A ≠ 0, PC ← ir[4:0].
  - 111 HALT.
  - 000, 001, 010: NOP.
- The datapath does no decoding. It obeys the strobes only.
- PC update: if `pc_load & jnz_mux`, PC ← `ir[4:0]`. Otherwise, if `pc_load`, PC ← PC+1 mod 2^ADDR_W (31 wraps to 0).
- IR update: when `ir_load`, IR ← mem[PC], using the PC value *before* this edge's increment.
- A update: when `a_load & inmux`, A ← `in_data`. When `a_load & ~inmux`, A ← A−1 mod 2^DATA_W (0 wraps to 255).
- Halt: `halt` sets `halted` at the edge. While `halted` = 1, PC, IR and A hold regardless of the strobes. Only `clear` releases it.
- Program memory:
  - 2^ADDR_W × DATA_W, asynchronous read at address PC.
  - Synchronous write when `prog_we`. Writes are accepted in any state, including halted.
  - A write and a fetch of the same address in the same cycle: IR gets the *old* word.
- `clear`: PC = 0, IR = 0, A = 0, `halted` = 0, so `an_0` = 0 and `out_data` = 0. Memory contents are not cleared. `clear` overrides every strobe and `prog_we` in the same cycle.

## Timing
- All registers update on the rising edge of `clock`. `an_0`, `out_data`, `ir` and `pc` reflect the new values immediately after that edge.
- Fetch (strobes `ir_load` + `pc_load`, `jnz_mux` = 0): 1 cycle. IR holds the new instruction at the next controller state (decode).
- `an_0` is valid in the same cycle that the controller samples it for JNZ, because it is derived from registered A.
- `clear` asserted mid-instruction: takes effect at the next edge, and no partial update survives.
- `prog_we` + `clear` in the same cycle: the write is dropped.

## Structure
- Shared package `cpu_pkg` holds:
  - `DATA_W` and `ADDR_W` defaults.
  - Opcode constants `OP_IN`, `OP_OUT`, `OP_DEC`, `OP_JNZ`, `OP_HALT`.
  - Controller state encodings.
- Sub-module `prog_mem`: 2^ADDR_W × DATA_W RAM with one async read port and one sync write port.
- PC, IR, A and the halt flag are implemented in `datapath` itself.
- Top-level `cpu` instantiates `control` + `datapath`. It is outside this block's scope but is used by test 5.

## Test plan
- Reset: drive arbitrary values into all registers, then assert `clear` 1 cycle → PC = 0, IR = 0, A = 0, `an_0` = 0, `halted` = 0. Memory is unchanged on readback.
- Fetch/wrap: mem[31] = 0x60, PC = 31, pulse `ir_load` + `pc_load` → IR = 0x60, PC = 0.
- A arithmetic:
  - `in_data` = 0x01, `a_load` + `inmux` → A = 1, `an_0` = 1.
  - DEC → A = 0, `an_0` = 0.
  - DEC again → A = 0xFF, `an_0` = 1.
- JNZ: IR = 0xC3.
  - With A = 5, pulse `pc_load` + `jnz_mux` → PC = 3.
  - With A = 0, the controller does not assert `pc_load` → PC holds.
- Program via `cpu`:
  - Load mem[0..3] = 0x60 (IN), 0xA0 (DEC), 0xC1 (JNZ 1), 0xE0 (HALT); `in_data` = 3.
  - Required result: `halted` = 1, A = 0, `out_data` = 0, PC = 4, reached after exactly 3 DEC executions.
- Halt hold: after halt, pulse every strobe → PC, IR and A unchanged. `prog_we` still writes. `clear` resumes from PC = 0.
